gray_seq_counter: RTL and testbench

Sequential source stage that drives the 4-bit binary-to-Gray converter input. It generates a binary up/down count at a prescaled rate, with synchronous load. It registers the binary value and its Gray encoding on the same edge, so both outputs stay cycle-aligned. It also flags wrap-around and self-checks the Gray single-bit-change property.

---
 rtl/gray_pkg.sv | 15 +
 rtl/gray_prescaler.sv | 27 ++
 rtl/gray_seq_counter.sv | 73 +++++++
 tb/tb_gray_seq_counter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared width constant and helpers for the Gray counter: binary-to-Gray
// encoding and an exactly-one-bit-set test used by the step checker.
package gray_pkg;

  localparam int GRAY_W = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic onehot_chk(input logic [31:0] x);
    return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/gray_prescaler.sv
// Divides enabled cycles by DIV: tick is high on the enabled cycle that
// completes a DIV-long run. The count holds while en is low; clr restarts it.
module gray_prescaler #(
  parameter int DIV = 1,
  parameter int PW  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (tick) pcnt <= '0;
      else      pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/gray_seq_counter.sv
// Prescaled up/down binary counter with registered Gray output, wrap and
// step pulses, and a sticky flag for any step that changes more than one Gray bit.
module gray_seq_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic             tick;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic [WIDTH-1:0] load_gray;
  logic             wrap_nxt;

  gray_prescaler #(
    .DIV (DIV),
    .PW  (PW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    bin_nxt   = up ? (bin_out + WIDTH'(1)) : (bin_out - WIDTH'(1));
    gray_nxt  = WIDTH'(bin2gray(32'(bin_nxt)));
    load_gray = WIDTH'(bin2gray(32'(load_val)));
    wrap_nxt  = up ? (bin_out == {WIDTH{1'b1}}) : (bin_out == {WIDTH{1'b0}});
  end

  // Only counting steps are checked; load and reset may jump arbitrarily.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else if (load) begin
      bin_out  <= load_val;
      gray_out <= load_gray;
      step     <= 1'b0;
      wrap     <= 1'b0;
    end else if (tick) begin
      bin_out  <= bin_nxt;
      gray_out <= gray_nxt;
      step     <= 1'b1;
      wrap     <= wrap_nxt;
      if (!onehot_chk(32'(gray_out ^ gray_nxt))) err <= 1'b1;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_seq_counter.sv
// Scoreboard bench for gray_seq_counter: a DIV=1 and a DIV=3 instance, driven
// with directed vectors whose expected outputs are queued and checked by a monitor.
module tb_gray_seq_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: DIV=1
  logic       a_rst = 1'b1, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
  logic [3:0] a_lv = 4'h0;
  logic [3:0] a_bin, a_gray;
  logic       a_step, a_wrap, a_err;

  // instance B: DIV=3
  logic       b_rst = 1'b1, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
  logic [3:0] b_lv = 4'h0;
  logic [3:0] b_bin, b_gray;
  logic       b_step, b_wrap, b_err;

  gray_seq_counter #(.WIDTH(4), .DIV(1)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load), .load_val(a_lv),
    .bin_out(a_bin), .gray_out(a_gray), .step(a_step), .wrap(a_wrap), .err(a_err)
  );

  gray_seq_counter #(.WIDTH(4), .DIV(3)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load), .load_val(b_lv),
    .bin_out(b_bin), .gray_out(b_gray), .step(b_step), .wrap(b_wrap), .err(b_err)
  );

  typedef struct {
    logic       sel;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       step;
    logic       wrap;
    logic       err;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: one queued expectation is consumed per clock, sampled after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] bin, gray;
      logic       stp, wrp, er;
      e = sb.pop_front();
      if (e.sel) begin
        bin = b_bin; gray = b_gray; stp = b_step; wrp = b_wrap; er = b_err;
      end else begin
        bin = a_bin; gray = a_gray; stp = a_step; wrp = a_wrap; er = a_err;
      end
      checks++;
      if (bin !== e.bin || gray !== e.gray || stp !== e.step || wrp !== e.wrap || er !== e.err) begin
        errors++;
        $display("FAIL %s: got bin=%h gray=%h step=%b wrap=%b err=%b, expected bin=%h gray=%h step=%b wrap=%b err=%b",
                 e.name, bin, gray, stp, wrp, er, e.bin, e.gray, e.step, e.wrap, e.err);
      end
    end
  end

  task automatic drv(input logic sel, input logic r, input logic e, input logic u,
                     input logic l, input logic [3:0] lv,
                     input logic [3:0] eb, input logic [3:0] eg,
                     input logic es, input logic ew, input string name);
    exp_t x;
    if (sel) begin
      b_rst = r; b_en = e; b_up = u; b_load = l; b_lv = lv;
    end else begin
      a_rst = r; a_en = e; a_up = u; a_load = l; a_lv = lv;
    end
    x.sel = sel; x.bin = eb; x.gray = eg; x.step = es; x.wrap = ew; x.err = 1'b0;
    x.name = name;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] gt [16];
    gt = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    @(negedge clk);

    // A: reset then up-count through wrap
    drv(0, 1, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, "a_reset0");
    drv(0, 1, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, "a_reset1");
    for (int k = 1; k <= 17; k++)
      drv(0, 0, 1, 1, 0, 4'h0, 4'(k % 16), gt[k % 16], 1, (k == 16), "a_up_count");

    // A: down wrap from reset
    drv(0, 1, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, "a_reset_dn");
    drv(0, 0, 1, 0, 0, 4'h0, 4'hF, 4'h8, 1, 1, "a_down_wrap");
    drv(0, 0, 1, 0, 0, 4'h0, 4'hE, 4'h9, 1, 0, "a_down_after");

    // A: up to 7, then reverse
    drv(0, 1, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, "a_reset_rev");
    for (int k = 1; k <= 7; k++)
      drv(0, 0, 1, 1, 0, 4'h0, 4'(k), gt[k], 1, 0, "a_rev_up");
    drv(0, 0, 1, 0, 0, 4'h0, 4'h6, 4'h5, 1, 0, "a_rev_dn6");
    drv(0, 0, 1, 0, 0, 4'h0, 4'h5, 4'h7, 1, 0, "a_rev_dn5");
    drv(0, 0, 0, 0, 0, 4'h0, 4'h5, 4'h7, 0, 0, "a_hold");

    // B: prescale by 3 with an en gap
    drv(1, 1, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, "b_reset");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, "b_pre_e1");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, "b_pre_e2");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 1, 0, "b_pre_e3");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 0, 0, "b_pre_e4");
    drv(1, 0, 0, 1, 0, 4'h0, 4'h1, 4'h1, 0, 0, "b_pre_off1");
    drv(1, 0, 0, 1, 0, 4'h0, 4'h1, 4'h1, 0, 0, "b_pre_off2");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 0, 0, "b_pre_e5");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h2, 4'h3, 1, 0, "b_pre_e6");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h2, 4'h3, 0, 0, "b_pre_e7");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h2, 4'h3, 0, 0, "b_pre_e8");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h3, 4'h2, 1, 0, "b_pre_e9");

    // B: load collides with a due step
    drv(1, 0, 0, 1, 1, 4'h5, 4'h5, 4'h7, 0, 0, "b_load5_en0");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h5, 4'h7, 0, 0, "b_ld_p1");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h5, 4'h7, 0, 0, "b_ld_p2");
    drv(1, 0, 1, 1, 1, 4'hA, 4'hA, 4'hF, 0, 0, "b_load_collide");
    drv(1, 0, 1, 1, 0, 4'h0, 4'hA, 4'hF, 0, 0, "b_post_ld1");
    drv(1, 0, 1, 1, 0, 4'h0, 4'hA, 4'hF, 0, 0, "b_post_ld2");
    drv(1, 0, 1, 1, 0, 4'h0, 4'hB, 4'hE, 1, 0, "b_post_ld_step");

    // B: reset mid-run at C
    drv(1, 0, 0, 1, 1, 4'hC, 4'hC, 4'hA, 0, 0, "b_load_c");
    drv(1, 0, 1, 1, 0, 4'h0, 4'hC, 4'hA, 0, 0, "b_run_c");
    drv(1, 1, 1, 1, 1, 4'h9, 4'h0, 4'h0, 0, 0, "b_mid_reset");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, "b_after_rst1");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, "b_after_rst2");
    drv(1, 0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 1, 0, "b_after_rst3");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left in queue, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
